hwpe_ctrl_regfile_arbiter: RTL and testbench

Shares the single read/write port pair of the HWPE control register file between two requesters: the host configuration port and the engine-side port. It does round-robin arbitration and generates one-cycle-latency responses that match the regfile's registered read address. It also protects job registers from host writes while the engine is locked, and sequences a single-cycle soft clear of the whole regfile. It sits between the peripheral slave interface / engine FSM and the regfile.

---
 rtl/hwpe_ctrl_regfile_arbiter.sv | 142 ++++++++++++++
 tb/tb_hwpe_ctrl_regfile_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_regfile_arbiter.sv
// Round-robin arbiter between the host config port and the engine port of the HWPE
// control regfile, with lock protection of job registers and a one-cycle soft clear.
module hwpe_ctrl_regfile_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LOCK_BASE  = 8,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req_i,
  input  logic                  lock_i,
  input  logic                  host_req_i,
  output logic                  host_gnt_o,
  input  logic                  host_wen_i,
  input  logic [ADDR_WIDTH-1:0] host_add_i,
  input  logic [NUM_BYTE-1:0]   host_be_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  input  logic [ID_WIDTH-1:0]   host_id_i,
  output logic                  host_r_valid_o,
  output logic [DATA_WIDTH-1:0] host_r_data_o,
  output logic [ID_WIDTH-1:0]   host_r_id_o,
  output logic                  host_r_err_o,
  input  logic                  eng_req_i,
  output logic                  eng_gnt_o,
  input  logic                  eng_we_i,
  input  logic [ADDR_WIDTH-1:0] eng_addr_i,
  input  logic [NUM_BYTE-1:0]   eng_be_i,
  input  logic [DATA_WIDTH-1:0] eng_wdata_i,
  output logic                  eng_r_valid_o,
  output logic [DATA_WIDTH-1:0] eng_r_data_o,
  output logic                  rf_read_en_o,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_read_data_i,
  output logic                  rf_write_en_o,
  output logic [ADDR_WIDTH-1:0] rf_write_addr_o,
  output logic [DATA_WIDTH-1:0] rf_write_data_o,
  output logic [NUM_BYTE-1:0]   rf_write_be_o,
  output logic                  rf_clear_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e state_q, state_d;
  logic   last_host_q, last_host_d;   // 1 = host won the most recent grant
  logic   host_win, eng_win, host_locked;

  logic                host_r_valid_q, host_rd_q, host_r_err_q;
  logic [ID_WIDTH-1:0] host_r_id_q;
  logic                eng_r_valid_q, eng_rd_q;

  assign host_locked = lock_i && !host_wen_i && (host_add_i >= ADDR_WIDTH'(LOCK_BASE));

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    last_host_d = last_host_q;
    host_win    = 1'b0;
    eng_win     = 1'b0;
    case (state_q)
      IDLE: begin
        host_win = host_req_i && (!eng_req_i || !last_host_q);
        eng_win  = eng_req_i && !host_win;
        if (host_win)     last_host_d = 1'b1;
        else if (eng_win) last_host_d = 1'b0;
        if (clear_req_i)  state_d = CLEAR;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_read_en_o    = 1'b0;
    rf_read_addr_o  = '0;
    rf_write_en_o   = 1'b0;
    rf_write_addr_o = '0;
    rf_write_data_o = '0;
    rf_write_be_o   = '0;
    if (host_win) begin
      if (host_wen_i) begin
        rf_read_en_o   = 1'b1;
        rf_read_addr_o = host_add_i;
      end else begin
        // A locked write is still granted and answered, just never reaches the regfile.
        rf_write_en_o   = !host_locked;
        rf_write_addr_o = host_add_i;
        rf_write_data_o = host_data_i;
        rf_write_be_o   = host_be_i;
      end
    end else if (eng_win) begin
      if (eng_we_i) begin
        rf_write_en_o   = 1'b1;
        rf_write_addr_o = eng_addr_i;
        rf_write_data_o = eng_wdata_i;
        rf_write_be_o   = eng_be_i;
      end else begin
        rf_read_en_o   = 1'b1;
        rf_read_addr_o = eng_addr_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_host_q    <= 1'b0;
      host_r_valid_q <= 1'b0;
      host_rd_q      <= 1'b0;
      host_r_err_q   <= 1'b0;
      host_r_id_q    <= '0;
      eng_r_valid_q  <= 1'b0;
      eng_rd_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_host_q    <= last_host_d;
      host_r_valid_q <= host_win;
      host_rd_q      <= host_win && host_wen_i;
      host_r_err_q   <= host_win && host_locked;
      host_r_id_q    <= host_win ? host_id_i : '0;
      eng_r_valid_q  <= eng_win;
      eng_rd_q       <= eng_win && !eng_we_i;
    end
  end

  assign host_gnt_o = host_win;
  assign eng_gnt_o  = eng_win;
  assign rf_clear_o = (state_q == CLEAR);
  assign busy_o     = (state_q == CLEAR);

  // Regfile read data is already aligned to the response cycle; only gate it.
  assign host_r_valid_o = host_r_valid_q;
  assign host_r_data_o  = (host_r_valid_q && host_rd_q) ? rf_read_data_i : '0;
  assign host_r_id_o    = host_r_id_q;
  assign host_r_err_o   = host_r_err_q;
  assign eng_r_valid_o  = eng_r_valid_q;
  assign eng_r_data_o   = (eng_r_valid_q && eng_rd_q) ? rf_read_data_i : '0;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_arbiter.sv
// Bench for hwpe_ctrl_regfile_arbiter: behavioural regfile, per-cycle reference model
// comparison on the falling edge, and directed scenarios with literal expectations.
module tb_hwpe_ctrl_regfile_arbiter;
  localparam int AW = 5, DW = 32, IW = 8, NB = 4, LB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clear_req_i, lock_i;
  logic          host_req_i, host_gnt_o, host_wen_i;
  logic [AW-1:0] host_add_i;
  logic [NB-1:0] host_be_i;
  logic [DW-1:0] host_data_i;
  logic [IW-1:0] host_id_i;
  logic          host_r_valid_o, host_r_err_o;
  logic [DW-1:0] host_r_data_o;
  logic [IW-1:0] host_r_id_o;
  logic          eng_req_i, eng_gnt_o, eng_we_i;
  logic [AW-1:0] eng_addr_i;
  logic [NB-1:0] eng_be_i;
  logic [DW-1:0] eng_wdata_i;
  logic          eng_r_valid_o;
  logic [DW-1:0] eng_r_data_o;
  logic          rf_read_en_o, rf_write_en_o, rf_clear_o, busy_o;
  logic [AW-1:0] rf_read_addr_o, rf_write_addr_o;
  logic [DW-1:0] rf_read_data_i, rf_write_data_o;
  logic [NB-1:0] rf_write_be_o;

  hwpe_ctrl_regfile_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LOCK_BASE(LB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_req_i(clear_req_i), .lock_i(lock_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_wen_i(host_wen_i),
    .host_add_i(host_add_i), .host_be_i(host_be_i), .host_data_i(host_data_i),
    .host_id_i(host_id_i), .host_r_valid_o(host_r_valid_o), .host_r_data_o(host_r_data_o),
    .host_r_id_o(host_r_id_o), .host_r_err_o(host_r_err_o),
    .eng_req_i(eng_req_i), .eng_gnt_o(eng_gnt_o), .eng_we_i(eng_we_i),
    .eng_addr_i(eng_addr_i), .eng_be_i(eng_be_i), .eng_wdata_i(eng_wdata_i),
    .eng_r_valid_o(eng_r_valid_o), .eng_r_data_o(eng_r_data_o),
    .rf_read_en_o(rf_read_en_o), .rf_read_addr_o(rf_read_addr_o),
    .rf_read_data_i(rf_read_data_i), .rf_write_en_o(rf_write_en_o),
    .rf_write_addr_o(rf_write_addr_o), .rf_write_data_o(rf_write_data_o),
    .rf_write_be_o(rf_write_be_o), .rf_clear_o(rf_clear_o), .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural regfile: registered read, byte-enabled write, synchronous clear.
  logic [DW-1:0] rf_mem [32];
  logic [DW-1:0] rf_rdata_q;
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rf_rdata_q = '0;
  end
  always @(posedge clk) begin
    if (rf_clear_o) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_write_en_o) begin
      for (int b = 0; b < NB; b++)
        if (rf_write_be_o[b]) rf_mem[rf_write_addr_o][8*b +: 8] <= rf_write_data_o[8*b +: 8];
    end
    if (rf_read_en_o) rf_rdata_q <= rf_mem[rf_read_addr_o];
  end
  assign rf_read_data_i = rf_rdata_q;

  // Reference model: expected regfile contents plus the response due next cycle.
  logic          m_clear, m_host_last;
  logic [DW-1:0] m_mem [32];
  logic          m_hv, m_herr, m_ev;
  logic [DW-1:0] m_hd, m_ed;
  logic [IW-1:0] m_hid;
  initial for (int i = 0; i < 32; i++) m_mem[i] = '0;

  function automatic logic exp_hg();
    return !m_clear && host_req_i && (!eng_req_i || !m_host_last);
  endfunction
  function automatic logic exp_eg();
    return !m_clear && eng_req_i && !exp_hg();
  endfunction
  function automatic logic host_is_locked();
    return lock_i && !host_wen_i && (host_add_i >= AW'(LB));
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic hw, ew;
    if (!rst_n) begin
      m_clear = 1'b0; m_host_last = 1'b0;
      m_hv = 1'b0; m_herr = 1'b0; m_hd = '0; m_hid = '0; m_ev = 1'b0; m_ed = '0;
    end else begin
      hw = exp_hg();
      ew = exp_eg();
      m_hv = 1'b0; m_herr = 1'b0; m_hd = '0; m_hid = '0; m_ev = 1'b0; m_ed = '0;
      if (m_clear) begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_clear = 1'b0;
      end else begin
        if (hw) begin
          m_host_last = 1'b1;
          m_hv  = 1'b1;
          m_hid = host_id_i;
          if (host_wen_i) m_hd = m_mem[host_add_i];
          else if (host_is_locked()) m_herr = 1'b1;
          else m_mem[host_add_i] = merge(m_mem[host_add_i], host_data_i, host_be_i);
        end else if (ew) begin
          m_host_last = 1'b0;
          m_ev = 1'b1;
          if (!eng_we_i) m_ed = m_mem[eng_addr_i];
          else m_mem[eng_addr_i] = merge(m_mem[eng_addr_i], eng_wdata_i, eng_be_i);
        end
        if (clear_req_i) m_clear = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic hg, eg, rd, wr;
    if (rst_n) begin
      hg = exp_hg();
      eg = exp_eg();
      rd = (hg && host_wen_i) || (eg && !eng_we_i);
      wr = (hg && !host_wen_i && !host_is_locked()) || (eg && eng_we_i);
      check("host_gnt", host_gnt_o, hg);
      check("eng_gnt", eng_gnt_o, eg);
      check("rf_clear", rf_clear_o, m_clear);
      check("busy", busy_o, m_clear);
      check("rf_read_en", rf_read_en_o, rd);
      check("rf_write_en", rf_write_en_o, wr);
      if (rd) check("rf_read_addr", rf_read_addr_o, hg ? host_add_i : eng_addr_i);
      if (wr) begin
        check("rf_write_addr", rf_write_addr_o, hg ? host_add_i : eng_addr_i);
        check("rf_write_data", rf_write_data_o, hg ? host_data_i : eng_wdata_i);
        check("rf_write_be", rf_write_be_o, hg ? host_be_i : eng_be_i);
      end
      check("host_r_valid", host_r_valid_o, m_hv);
      check("host_r_data", host_r_data_o, m_hd);
      check("host_r_err", host_r_err_o, m_herr);
      if (m_hv) check("host_r_id", host_r_id_o, m_hid);
      check("eng_r_valid", eng_r_valid_o, m_ev);
      check("eng_r_data", eng_r_data_o, m_ed);
    end
  end

  task automatic drive(input logic hr, input logic hwen, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd, input logic [NB-1:0] hb, input logic [IW-1:0] hid,
                       input logic er, input logic ewe, input logic [AW-1:0] ea,
                       input logic [DW-1:0] ed, input logic [NB-1:0] eb,
                       input logic clr, input logic lk);
    host_req_i = hr; host_wen_i = hwen; host_add_i = ha; host_data_i = hd;
    host_be_i = hb; host_id_i = hid;
    eng_req_i = er; eng_we_i = ewe; eng_addr_i = ea; eng_wdata_i = ed; eng_be_i = eb;
    clear_req_i = clr; lock_i = lk;
  endtask

  task automatic idle();
    drive(0, 1, '0, '0, '0, '0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_host_r_valid", host_r_valid_o, 0);
    check("rst_eng_r_valid", eng_r_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rf_clear", rf_clear_o, 0);
    rst_n = 1'b1;

    // Host write then read-back of addr 3.
    drive(1, 0, 5'd3, 32'hDEADBEEF, 4'hF, 8'h11, 0, 0, '0, '0, '0, 0, 0);
    @(negedge clk);
    check("t1_wr_gnt", host_gnt_o, 1);
    check("t1_wr_en", rf_write_en_o, 1);
    next();
    drive(1, 1, 5'd3, '0, 4'hF, 8'h22, 0, 0, '0, '0, '0, 0, 0);
    @(negedge clk);
    check("t1_rd_gnt", host_gnt_o, 1);
    check("t1_wr_resp_id", host_r_id_o, 8'h11);
    next();
    idle();
    @(negedge clk);
    check("t1_rd_valid", host_r_valid_o, 1);
    check("t1_rd_data", host_r_data_o, 32'hDEADBEEF);
    check("t1_rd_id", host_r_id_o, 8'h22);
    next();

    // Round robin from a fresh reset: HOST, ENG, HOST, ENG.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1, 1, 5'd4, '0, 4'hF, 8'h40, 1, 0, 5'd6, '0, 4'hF, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_host_gnt", host_gnt_o, (k % 2) == 0);
      check("t2_eng_gnt", eng_gnt_o, (k % 2) == 1);
      check("t2_rd_addr", rf_read_addr_o, ((k % 2) == 0) ? 5'd4 : 5'd6);
      next();
    end
    idle();
    next();

    // Lock protection.
    drive(0, 1, '0, '0, '0, '0, 1, 1, 5'd9, 32'h1234, 4'hF, 0, 1);
    @(negedge clk);
    check("t3_eng_wr_en", rf_write_en_o, 1);
    next();
    drive(1, 0, 5'd9, 32'h55, 4'hF, 8'h33, 0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    check("t3_lock_gnt", host_gnt_o, 1);
    check("t3_lock_wr_en", rf_write_en_o, 0);
    next();
    drive(1, 1, 5'd9, '0, 4'hF, 8'h34, 0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    check("t3_lock_err", host_r_err_o, 1);
    next();
    drive(1, 0, 5'd2, 32'h55, 4'hF, 8'h35, 0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    check("t3_old_value", host_r_data_o, 32'h1234);
    check("t3_rd_err", host_r_err_o, 0);
    check("t3_low_wr_en", rf_write_en_o, 1);
    next();
    drive(1, 0, 5'd2, 32'hFFFFFFFF, 4'b0100, 8'h36, 0, 0, '0, '0, '0, 0, 0);
    @(negedge clk);
    check("t3_low_err", host_r_err_o, 0);
    next();
    drive(1, 1, 5'd2, '0, 4'hF, 8'h37, 0, 0, '0, '0, '0, 0, 0);
    next();
    idle();
    @(negedge clk);
    check("t3_partial_be", host_r_data_o, 32'h00FF0055);
    next();

    // Fill every word, then soft clear with an engine read in the request cycle.
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) drive(1, 0, AW'(i), 32'hA5000000 + i, 4'hF, 8'(i), 0, 0, '0, '0, '0, 0, 0);
      else drive(0, 1, '0, '0, '0, '0, 1, 1, AW'(i), 32'hA5000000 + i, 4'hF, 0, 0);
      next();
    end
    drive(0, 1, '0, '0, '0, '0, 1, 0, 5'd5, '0, '0, 1, 0);
    @(negedge clk);
    check("t4_req_cycle_gnt", eng_gnt_o, 1);
    next();
    drive(1, 1, 5'd7, '0, 4'hF, 8'h70, 1, 0, 5'd8, '0, '0, 1, 0);
    @(negedge clk);
    check("t4_rf_clear", rf_clear_o, 1);
    check("t4_busy", busy_o, 1);
    check("t4_host_gnt", host_gnt_o, 0);
    check("t4_eng_gnt", eng_gnt_o, 0);
    check("t4_eng_r_valid", eng_r_valid_o, 1);
    check("t4_preclear", eng_r_data_o, 32'hA5000005);
    next();
    drive(1, 1, 5'd7, '0, 4'hF, 8'h70, 1, 0, 5'd8, '0, '0, 0, 0);
    @(negedge clk);
    check("t4_merged_idle", busy_o, 0);
    check("t4_after_host", host_gnt_o, 1);
    next();
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, AW'(i), '0, 4'hF, 8'(i), 0, 0, '0, '0, '0, 0, 0);
      next();
    end
    idle();
    @(negedge clk);
    check("t4_rd31_zero", host_r_data_o, 0);
    check("t4_rd31_valid", host_r_valid_o, 1);
    next();

    // Reset asserted during CLEAR; last winner before it was the host.
    drive(1, 1, 5'd5, '0, 4'hF, 8'h55, 0, 0, '0, '0, '0, 1, 0);
    next();
    idle();
    @(negedge clk);
    check("t6_busy_before", busy_o, 1);
    check("t6_valid_before", host_r_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rf_clear_rst", rf_clear_o, 0);
    check("t6_busy_rst", busy_o, 0);
    check("t6_valid_rst", host_r_valid_o, 0);
    next();
    rst_n = 1'b1;
    drive(1, 1, 5'd1, '0, 4'hF, 8'h66, 1, 0, 5'd2, '0, '0, 0, 0);
    @(negedge clk);
    check("t6_host_first", host_gnt_o, 1);
    check("t6_eng_waits", eng_gnt_o, 0);
    next();
    idle();
    repeat (2) next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
